xif_copro_result_handler: RTL and testbench
===========================================

XIF_COPRO_RESULT_HANDLER -- requirements
Module: xif_copro_result_handler

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, result FIFO entries; power of two, >= 2.
REQ-002 The module SHALL have parameter X_ID_WIDTH, default 4, XIF instruction id width.
REQ-003 The module SHALL have parameter XLEN, default 32, result data width.
REQ-004 The module SHALL use one clock and an asynchronous active-low reset, as listed below:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- flush_i  input  1  synchronous clear of FIFO and kill table.
- exec_valid_i  input  1  execution unit result valid.
- exec_ready_o  output  1  result accepted.
- exec_id_i  input  X_ID_WIDTH  instruction id.
- exec_rd_i  input  5  destination register.
- exec_we_i  input  1  register write enable.
- exec_data_i  input  XLEN  result data.
- commit_valid_i  input  1  XIF commit valid.
- commit_id_i  input  X_ID_WIDTH  committed id.
- commit_kill_i  input  1  instruction killed.
- result_valid_o  output  1  XIF result valid.
- result_ready_i  input  1  core accepts result.
- result_id_o  output  X_ID_WIDTH  result id.
- result_rd_o  output  5  result rd.
- result_we_o  output  1  result write enable.
- result_data_o  output  XLEN  result data.
- count_o  output  $clog2(DEPTH)+1  occupied entries.

Function
REQ-005 An exec transfer SHALL occur when exec_valid_i and exec_ready_o are both high, and SHALL write {id, rd, we, data} at the write pointer.
REQ-006 exec_ready_o SHALL be !full. It SHALL NOT depend on result_ready_i.
REQ-007 The kill table SHALL be a 2^X_ID_WIDTH bit vector. A bit SHALL be set on the clock edge after commit_valid_i && commit_kill_i, at index commit_id_i.
REQ-008 A non-empty FIFO whose head id has its kill bit set SHALL drop the head in one cycle, with result_valid_o low that cycle, and SHALL clear that kill bit.
REQ-009 A non-empty FIFO whose head is not killed SHALL drive result_valid_o high with the head fields, and SHALL pop on result_valid_o && result_ready_i.
REQ-010 The kill bit SHALL be cleared whenever a head with that id departs (pop or drop). A same-cycle set for the same id SHALL lose to the clear.
REQ-011 Once result_valid_o is high, the output fields SHALL be held stable until the transfer. The only exceptions SHALL be flush_i and reset.
REQ-012 When result_valid_o is low, result_id_o, result_rd_o, result_we_o and result_data_o SHALL be 0.
REQ-013 A simultaneous push and pop SHALL leave count_o unchanged. This SHALL include push while full-and-popping being refused, per REQ-006.
REQ-014 Pointers SHALL wrap modulo DEPTH. count_o SHALL range from 0 to DEPTH.
REQ-015 Results SHALL be delivered in acceptance order. There SHALL be no reordering by id.
REQ-016 Without bypass, latency from exec transfer to result_valid_o SHALL be 1 cycle minimum.
REQ-017 flush_i SHALL take priority over push, pop and kill-set in the same cycle. On the next cycle count_o SHALL be 0 and the kill table SHALL be all-zero.

Reset
REQ-018 While rst_ni is low, the following SHALL hold asynchronously:
- pointers = 0, count_o = 0, kill table = 0.
- result_valid_o = 0, all result fields = 0.
- exec_ready_o = 1 after reset release.
REQ-019 Reset asserted mid-transfer SHALL discard all stored results. No partial entry SHALL survive.

Configuration
REQ-020 When XIF_COPRO_RESULT_BYPASS_EN is defined, an empty, non-flushing FIFO SHALL route exec_valid_i and the exec fields combinationally to the result outputs if exec_id_i's kill bit is clear:
- If result_ready_i is high, the entry SHALL NOT be written.
- Otherwise the entry SHALL be written normally.
- In both cases latency SHALL be 0 cycles.
REQ-021 When XIF_COPRO_RESULT_BYPASS_EN is undefined, no combinational path from exec_* to result_* SHALL exist, and REQ-016 latency SHALL apply.

Verification
REQ-022 The bench SHALL cover these directed scenarios (without bypass unless stated):
- Basic: push id=3, rd=5, we=1, data=0xDEADBEEF, result_ready_i=1 -> result_valid_o next cycle with those fields, then count_o=0.
- Full: result_ready_i=0, push 4 entries -> count_o=4, exec_ready_o=0. Then ready=1 -> 4 results in order, one per cycle.
- Kill: commit kill id=2, then push id=2 and id=7 -> id=2 dropped without result_valid_o, id=7 delivered, kill bit 2 cleared.
- Kill race: head id=1 popped in the same cycle as commit kill id=1 -> bit 1 = 0 afterwards, and a later id=1 result is delivered.
- Flush: count_o=3 with kill bit 4 set, assert flush_i together with a push -> count_o=0, table 0, push discarded.
- Bypass (XIF_COPRO_RESULT_BYPASS_EN defined): empty, ready=1, push id=9, data=0x1234 -> result_valid_o in the same cycle, count_o stays 0.

Source files
------------

// File: rtl/xif_copro_result_handler.sv
// xif_copro_result_handler
// Buffers execution-unit results in a DEPTH-entry FIFO and presents them on
// the XIF result interface in acceptance order. A kill table indexed by
// instruction id marks instructions killed at commit; a killed result is
// silently dropped when it reaches the FIFO head.
// Optional feature macro: XIF_COPRO_RESULT_BYPASS_EN -- when defined, an empty
// FIFO forwards the exec result combinationally to the result port.
module xif_copro_result_handler #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned X_ID_WIDTH = 4,
  parameter int unsigned XLEN       = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      flush_i,
  input  logic                      exec_valid_i,
  output logic                      exec_ready_o,
  input  logic [X_ID_WIDTH-1:0]     exec_id_i,
  input  logic [4:0]                exec_rd_i,
  input  logic                      exec_we_i,
  input  logic [XLEN-1:0]           exec_data_i,
  input  logic                      commit_valid_i,
  input  logic [X_ID_WIDTH-1:0]     commit_id_i,
  input  logic                      commit_kill_i,
  output logic                      result_valid_o,
  input  logic                      result_ready_i,
  output logic [X_ID_WIDTH-1:0]     result_id_o,
  output logic [4:0]                result_rd_o,
  output logic                      result_we_o,
  output logic [XLEN-1:0]           result_data_o,
  output logic [$clog2(DEPTH):0]    count_o
);

  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam int unsigned NID = 1 << X_ID_WIDTH;

  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  // FIFO storage
  logic [X_ID_WIDTH-1:0] r_fifo_id   [DEPTH];
  logic [4:0]            r_fifo_rd   [DEPTH];
  logic                  r_fifo_we   [DEPTH];
  logic [XLEN-1:0]       r_fifo_data [DEPTH];

  logic [PW-1:0]  r_wptr;
  logic [PW-1:0]  r_rptr;
  logic [CW-1:0]  r_count;
  logic [NID-1:0] r_kill;
  // Set while a result is being offered but not yet accepted; freezes the
  // head so a late kill cannot retract an offered result.
  logic           r_hold;

  logic                  w_empty;
  logic                  w_full;
  logic [X_ID_WIDTH-1:0] w_head_id;
  logic                  w_head_killed;
  logic                  w_head_valid;
  logic                  w_bypass;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_kill_set;
  logic [CW-1:0]         w_count_nxt;

  // Occupancy, head status, bypass qualification and push/pop decisions
  always_comb begin
    w_empty       = (r_count == {CW{1'b0}});
    w_full        = (r_count == CNT_FULL);
    w_head_id     = r_fifo_id[r_rptr];
    w_head_killed = !w_empty && !r_hold && r_kill[w_head_id];
    w_head_valid  = !w_empty && !w_head_killed;
`ifdef XIF_COPRO_RESULT_BYPASS_EN
    w_bypass      = rst_ni && w_empty && !flush_i && exec_valid_i && !r_kill[exec_id_i];
`else
    w_bypass      = 1'b0;
`endif
    // A bypassed result taken by the core in the same cycle never enters the FIFO.
    w_push        = exec_valid_i && !w_full && !flush_i && !(w_bypass && result_ready_i);
    w_pop         = !flush_i && ((w_head_valid && result_ready_i) || w_head_killed);
    w_kill_set    = !flush_i && commit_valid_i && commit_kill_i;
    exec_ready_o  = !w_full;
    count_o       = r_count;
  end

  // Result port: head fields when a live head exists, zeros when idle
  always_comb begin
    result_valid_o = 1'b0;
    result_id_o    = {X_ID_WIDTH{1'b0}};
    result_rd_o    = 5'd0;
    result_we_o    = 1'b0;
    result_data_o  = {XLEN{1'b0}};
    if (w_head_valid) begin
      result_valid_o = 1'b1;
      result_id_o    = w_head_id;
      result_rd_o    = r_fifo_rd[r_rptr];
      result_we_o    = r_fifo_we[r_rptr];
      result_data_o  = r_fifo_data[r_rptr];
    end
`ifdef XIF_COPRO_RESULT_BYPASS_EN
    else if (w_bypass) begin
      result_valid_o = 1'b1;
      result_id_o    = exec_id_i;
      result_rd_o    = exec_rd_i;
      result_we_o    = exec_we_i;
      result_data_o  = exec_data_i;
    end
`endif
    else begin
      result_valid_o = 1'b0;
    end
  end

  // Next occupancy from push/pop pair
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_ONE;
      2'b01:   w_count_nxt = r_count - CNT_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  // Pointers, occupancy and offer-hold flag
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= {PW{1'b0}};
      r_rptr  <= {PW{1'b0}};
      r_count <= {CW{1'b0}};
      r_hold  <= 1'b0;
    end else if (flush_i) begin
      r_wptr  <= {PW{1'b0}};
      r_rptr  <= {PW{1'b0}};
      r_count <= {CW{1'b0}};
      r_hold  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      r_count <= w_count_nxt;
      r_hold  <= result_valid_o && !result_ready_i;
    end
  end

  // Entry storage written at the write pointer on an accepted push
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_fifo_id[i]   <= {X_ID_WIDTH{1'b0}};
        r_fifo_rd[i]   <= 5'd0;
        r_fifo_we[i]   <= 1'b0;
        r_fifo_data[i] <= {XLEN{1'b0}};
      end
    end else if (w_push) begin
      r_fifo_id[r_wptr]   <= exec_id_i;
      r_fifo_rd[r_wptr]   <= exec_rd_i;
      r_fifo_we[r_wptr]   <= exec_we_i;
      r_fifo_data[r_wptr] <= exec_data_i;
    end
  end

  // Kill table: set on commit-kill, cleared when a head with that id departs;
  // the clear is written last so it wins over a same-cycle set.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_kill <= {NID{1'b0}};
    end else if (flush_i) begin
      r_kill <= {NID{1'b0}};
    end else begin
      if (w_kill_set) begin
        r_kill[commit_id_i] <= 1'b1;
      end
      if (w_pop) begin
        r_kill[w_head_id] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_xif_copro_result_handler.sv
// Self-checking bench for xif_copro_result_handler: table-driven vectors plus
// directed multi-cycle sequences, with a scoreboard queue of expected results
// compared by a monitor whenever a result transfer occurs.
module tb_xif_copro_result_handler;

`ifdef XIF_COPRO_RESULT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_i = 1'b0;
  logic        exec_valid_i = 1'b0;
  logic        exec_ready_o;
  logic [3:0]  exec_id_i = 4'd0;
  logic [4:0]  exec_rd_i = 5'd0;
  logic        exec_we_i = 1'b0;
  logic [31:0] exec_data_i = 32'd0;
  logic        commit_valid_i = 1'b0;
  logic [3:0]  commit_id_i = 4'd0;
  logic        commit_kill_i = 1'b0;
  logic        result_valid_o;
  logic        result_ready_i = 1'b0;
  logic [3:0]  result_id_o;
  logic [4:0]  result_rd_o;
  logic        result_we_o;
  logic [31:0] result_data_o;
  logic [2:0]  count_o;

  xif_copro_result_handler #(.DEPTH(4), .X_ID_WIDTH(4), .XLEN(32)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .flush_i        (flush_i),
    .exec_valid_i   (exec_valid_i),
    .exec_ready_o   (exec_ready_o),
    .exec_id_i      (exec_id_i),
    .exec_rd_i      (exec_rd_i),
    .exec_we_i      (exec_we_i),
    .exec_data_i    (exec_data_i),
    .commit_valid_i (commit_valid_i),
    .commit_id_i    (commit_id_i),
    .commit_kill_i  (commit_kill_i),
    .result_valid_o (result_valid_o),
    .result_ready_i (result_ready_i),
    .result_id_o    (result_id_o),
    .result_rd_o    (result_rd_o),
    .result_we_o    (result_we_o),
    .result_data_o  (result_data_o),
    .count_o        (count_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  id;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] data;
  } res_t;

  typedef struct {
    logic [3:0]  id;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] data;
    bit          kill;
    bit          rdy;
  } vec_t;

  res_t sb[$];
  vec_t tbl[8];
  int   n_pass = 0;
  int   n_total = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endfunction

  // Monitor: compare every result transfer against the scoreboard head and
  // require zeroed fields whenever no result is offered.
  always @(negedge clk) begin
    res_t act;
    res_t exp;
    if (rst_n) begin
      act = '{id: result_id_o, rd: result_rd_o, we: result_we_o, data: result_data_o};
      if (result_valid_o && result_ready_i) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_result: got id 0x%0h data 0x%0h, expected no result", result_id_o, result_data_o);
        end else begin
          exp = sb.pop_front();
          check("result_fields", 64'(act), 64'(exp));
        end
      end else if (!result_valid_o) begin
        check("idle_fields_zero", 64'(act), 64'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] id, input logic [4:0] rd, input logic we,
                      input logic [31:0] d, input bit deliver);
    int w = 0;
    while (!exec_ready_o && w < 50) begin
      tick();
      w++;
    end
    if (!exec_ready_o) begin
      n_total++;
      $display("FAIL push_ready_timeout: got exec_ready_o 0, expected 1 within 50 cycles");
    end
    exec_valid_i = 1'b1;
    exec_id_i    = id;
    exec_rd_i    = rd;
    exec_we_i    = we;
    exec_data_i  = d;
    if (deliver) sb.push_back('{id: id, rd: rd, we: we, data: d});
    tick();
    exec_valid_i = 1'b0;
  endtask

  task automatic kill(input logic [3:0] id);
    commit_valid_i = 1'b1;
    commit_kill_i  = 1'b1;
    commit_id_i    = id;
    tick();
    commit_valid_i = 1'b0;
    commit_kill_i  = 1'b0;
  endtask

  task automatic drain(input string name);
    int w = 0;
    while ((sb.size() != 0 || count_o != 3'd0) && w < 100) begin
      tick();
      w++;
    end
    check(name, {32'(sb.size()), 29'd0, count_o}, 64'd0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{4'h1, 5'd1,  1'b1, 32'h0000_0001, 1'b0, 1'b1};
    tbl[1] = '{4'h2, 5'd31, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0};
    tbl[2] = '{4'h3, 5'd0,  1'b1, 32'h0000_0000, 1'b1, 1'b1};
    tbl[3] = '{4'h4, 5'd17, 1'b1, 32'hA5A5_5A5A, 1'b0, 1'b1};
    tbl[4] = '{4'h5, 5'd8,  1'b0, 32'h8000_0000, 1'b0, 1'b0};
    tbl[5] = '{4'hF, 5'd2,  1'b1, 32'h1357_9BDF, 1'b1, 1'b1};
    tbl[6] = '{4'h0, 5'd30, 1'b1, 32'h0F0F_0F0F, 1'b0, 1'b0};
    tbl[7] = '{4'hE, 5'd12, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1};

    // Reset state
    #12;
    check("reset_valid", 64'(result_valid_o), 64'd0);
    check("reset_count", 64'(count_o), 64'd0);
    check("reset_data", 64'(result_data_o), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("ready_after_reset", 64'(exec_ready_o), 64'd1);

    // Basic transfer and latency
    result_ready_i = 1'b1;
    exec_valid_i = 1'b1; exec_id_i = 4'd3; exec_rd_i = 5'd5; exec_we_i = 1'b1; exec_data_i = 32'hDEAD_BEEF;
    sb.push_back('{id: 4'd3, rd: 5'd5, we: 1'b1, data: 32'hDEAD_BEEF});
    #1;
    check("basic_same_cycle_valid", 64'(result_valid_o), 64'(BYP));
    tick();
    exec_valid_i = 1'b0;
    #1;
    check("basic_next_cycle_valid", 64'(result_valid_o), 64'(!BYP));
    check("basic_next_cycle_count", 64'(count_o), 64'(!BYP));
    tick();
    check("basic_count_after", 64'(count_o), 64'd0);

    // Full FIFO, hold while stalled, then ordered drain one per cycle
    result_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) push(4'(8 + i), 5'(i + 1), 1'b1, 32'h1000_0000 + 32'(i), 1'b1);
    check("full_count", 64'(count_o), 64'd4);
    check("full_exec_ready", 64'(exec_ready_o), 64'd0);
    check("full_head_valid", 64'(result_valid_o), 64'd1);
    tick();
    check("full_head_held", 64'(result_id_o), 64'd8);
    result_ready_i = 1'b1;
    exec_valid_i = 1'b1; exec_id_i = 4'hF; exec_data_i = 32'hBAD0_0000;
    tick();
    exec_valid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("full_drain_count", 64'(count_o), 64'(3 - k));
      tick();
    end
    check("full_drain_empty", 64'(count_o), 64'd0);

    // Kill: id 2 dropped silently, id 7 delivered, bit 2 cleared afterwards
    kill(4'd2);
    push(4'd2, 5'd9, 1'b1, 32'h2222_2222, 1'b0);
    check("kill_drop_no_valid", 64'(result_valid_o), 64'd0);
    check("kill_drop_count", 64'(count_o), 64'd1);
    push(4'd7, 5'd7, 1'b0, 32'h7777_7777, 1'b1);
    drain("kill_drain");
    push(4'd2, 5'd3, 1'b1, 32'h2020_2020, 1'b1);
    drain("kill_bit_cleared");

    // Kill race: pop of id 1 in the same cycle as commit kill id 1
    result_ready_i = 1'b0;
    push(4'd1, 5'd11, 1'b1, 32'h1111_0001, 1'b1);
    result_ready_i = 1'b1;
    commit_valid_i = 1'b1; commit_kill_i = 1'b1; commit_id_i = 4'd1;
    tick();
    commit_valid_i = 1'b0; commit_kill_i = 1'b0;
    check("race_count", 64'(count_o), 64'd0);
    push(4'd1, 5'd12, 1'b0, 32'h1111_0002, 1'b1);
    drain("race_later_id1");

    // Flush with a concurrent push clears FIFO and kill table
    result_ready_i = 1'b0;
    kill(4'd4);
    push(4'd10, 5'd1, 1'b1, 32'hA000_0000, 1'b0);
    push(4'd11, 5'd2, 1'b1, 32'hB000_0000, 1'b0);
    push(4'd12, 5'd3, 1'b1, 32'hC000_0000, 1'b0);
    check("flush_pre_count", 64'(count_o), 64'd3);
    flush_i = 1'b1;
    exec_valid_i = 1'b1; exec_id_i = 4'd13; exec_data_i = 32'hD000_0000;
    tick();
    flush_i = 1'b0;
    exec_valid_i = 1'b0;
    check("flush_count", 64'(count_o), 64'd0);
    check("flush_valid", 64'(result_valid_o), 64'd0);
    result_ready_i = 1'b1;
    push(4'd4, 5'd4, 1'b1, 32'h4444_4444, 1'b1);
    drain("flush_kill_table_clear");

    // Reset mid-transfer discards stored results
    result_ready_i = 1'b0;
    push(4'd5, 5'd5, 1'b1, 32'h5555_5555, 1'b0);
    push(4'd6, 5'd6, 1'b1, 32'h6666_6666, 1'b0);
    check("prereset_count", 64'(count_o), 64'd2);
    rst_n = 1'b0;
    #1;
    check("async_reset_count", 64'(count_o), 64'd0);
    check("async_reset_valid", 64'(result_valid_o), 64'd0);
    tick();
    rst_n = 1'b1;
    result_ready_i = 1'b1;
    push(4'd6, 5'd16, 1'b0, 32'h6060_6060, 1'b1);
    drain("post_reset_fresh");

`ifdef XIF_COPRO_RESULT_BYPASS_EN
    // Bypass: empty FIFO and ready core gives a same-cycle result
    exec_valid_i = 1'b1; exec_id_i = 4'd9; exec_rd_i = 5'd1; exec_we_i = 1'b1; exec_data_i = 32'h0000_1234;
    sb.push_back('{id: 4'd9, rd: 5'd1, we: 1'b1, data: 32'h0000_1234});
    #1;
    check("bypass_valid", 64'(result_valid_o), 64'd1);
    check("bypass_data", 64'(result_data_o), 64'h1234);
    tick();
    exec_valid_i = 1'b0;
    check("bypass_count", 64'(count_o), 64'd0);
`endif

    // Table-driven vectors
    for (int i = 0; i < 8; i++) begin
      result_ready_i = tbl[i].rdy;
      if (tbl[i].kill) kill(tbl[i].id);
      push(tbl[i].id, tbl[i].rd, tbl[i].we, tbl[i].data, !tbl[i].kill);
    end
    result_ready_i = 1'b1;
    drain("table_drain");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
